// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and default busy-cycle counts.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_MADD  = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MFHI  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    function automatic logic is_multi_cycle(input logic [2:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_divide(input logic [2:0] op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/md_if.sv
// Signals between the EX-stage datapath/decoder (master) and the multiply/divide
// unit (slave).
interface md_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        d_md_stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    modport master (
        output start, op, a, b, flush, d_md_stall,
        input  busy, hi, lo, stall
    );

    modport slave (
        input  start, op, a, b, flush, d_md_stall,
        output busy, hi, lo, stall
    );
endinterface

// File: rtl/md_calc.sv
// Combinational arithmetic for the md unit: 64-bit {hi,lo} result for the
// multi-cycle ops, plus a divide-by-zero flag.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign a_neg  = (op == MD_DIV) && a[31];
    assign b_neg  = (op == MD_DIV) && b[31];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign b_safe = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem    = a_neg ? -r_mag : r_mag;

    always_comb begin
        result = {hi, lo};
        div0   = 1'b0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_DIV, MD_DIVU: begin
                result = {rem, quot};
                div0   = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences multi-cycle busy timing
// and raises the D-stage stall request.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    md_if.slave  bus
);

    md_state_e   state;
    md_state_e   state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [31:0] tmp_hi;
    logic [31:0] tmp_lo;
    logic [31:0] tmp_hi_next;
    logic [31:0] tmp_lo_next;
    logic        skip_q;
    logic        skip_next;
    logic [63:0] calc_result;
    logic        calc_div0;
    logic        busy;
    logic        eff_start;
    logic        multi;

    md_calc u_calc (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (calc_result),
        .div0   (calc_div0)
    );

    assign busy      = (state == RUN);
    assign multi     = is_multi_cycle(bus.op);
    assign eff_start = bus.start & ~bus.flush & ~busy;

    assign bus.busy  = busy;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = bus.d_md_stall & (busy | (bus.start & ~bus.flush & multi));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            skip_q <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            hi_q   <= hi_next;
            lo_q   <= lo_next;
            tmp_hi <= tmp_hi_next;
            tmp_lo <= tmp_lo_next;
            skip_q <= skip_next;
        end
    end

    // The result is frozen at start; a divide by zero only suppresses the commit.
    always_comb begin
        state_next  = state;
        count_next  = count;
        hi_next     = hi_q;
        lo_next     = lo_q;
        tmp_hi_next = tmp_hi;
        tmp_lo_next = tmp_lo;
        skip_next   = skip_q;
        case (state)
            IDLE: begin
                if (eff_start) begin
                    if (multi) begin
                        state_next  = RUN;
                        count_next  = is_divide(bus.op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        tmp_hi_next = calc_result[63:32];
                        tmp_lo_next = calc_result[31:0];
                        skip_next   = calc_div0;
                    end else if (bus.op == MD_MTHI) begin
                        hi_next = bus.a;
                    end else if (bus.op == MD_MTLO) begin
                        lo_next = bus.a;
                    end
                end
            end
            RUN: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = IDLE;
                    if (!skip_q) begin
                        hi_next = tmp_hi;
                        lo_next = tmp_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected {hi,lo} results are queued at start and
// compared when busy falls.
module tb_md_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] sb[$];

    md_if bus();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one start cycle; afterwards scramble the operands to prove they were captured.
    task automatic apply_stimulus(input logic [2:0] op_v, input logic [31:0] a_v,
                                  input logic [31:0] b_v, input logic [63:0] exp_res,
                                  input logic push, input logic exp_stall, input string tag);
        bus.start = 1'b1;
        bus.flush = 1'b0;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        #1;
        check_output({tag, " start stall"}, 64'(bus.stall), 64'(exp_stall));
        if (push) sb.push_back(exp_res);
        tick();
        bus.start = 1'b0;
        bus.a     = ~a_v;
        bus.b     = b_v + 32'd5;
    endtask

    task automatic wait_commit(input int n_exp, input string tag);
        int n;
        int n_stall;
        logic [63:0] exp_v;
        n = 0;
        n_stall = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            if (bus.stall === 1'b1) n_stall++;
            tick();
            n++;
        end
        check_output({tag, " busy cycles"}, 64'(n), 64'(n_exp));
        check_output({tag, " busy stall cycles"}, 64'(n_stall),
                     bus.d_md_stall ? 64'(n_exp) : 64'd0);
        check_output({tag, " stall after"}, 64'(bus.stall), 64'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            exp_v = sb.pop_front();
            check_output({tag, " hi/lo"}, {bus.hi, bus.lo}, exp_v);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.op         = MD_MULT;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        bus.flush      = 1'b0;
        bus.d_md_stall = 1'b1;
        tick();
        tick();
        check_output("reset busy", 64'(bus.busy), 64'd0);
        check_output("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        check_output("reset stall", 64'(bus.stall), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("[TB] mult -2 * 3 with D-stage stall");
        apply_stimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b1, "mult");
        wait_commit(5, "mult");

        bus.d_md_stall = 1'b0;
        apply_stimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, "multu");
        wait_commit(5, "multu");

        apply_stimulus(MD_MADD, 32'd2, 32'd3, 64'hFFFF_FFFE_0000_0007, 1'b1, 1'b0, "madd");
        check_output("madd hi/lo held while busy", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        wait_commit(5, "madd");

        bus.d_md_stall = 1'b1;
        apply_stimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, "div -7/2");
        wait_commit(10, "div -7/2");
        bus.d_md_stall = 1'b0;

        apply_stimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 1'b0, "div ovf");
        wait_commit(10, "div ovf");

        $display("[TB] mthi/mtlo preload then divu by zero");
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.a     = 32'h11;
        tick();
        bus.op    = MD_MTLO;
        bus.a     = 32'h22;
        check_output("mthi busy", 64'(bus.busy), 64'd0);
        check_output("mthi hi", 64'(bus.hi), 64'h11);
        tick();
        bus.start = 1'b0;
        check_output("mtlo busy", 64'(bus.busy), 64'd0);
        check_output("mtlo hi/lo", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);

        apply_stimulus(MD_DIVU, 32'd100, 32'd0, 64'h0000_0011_0000_0022, 1'b1, 1'b0, "divu b=0");
        wait_commit(10, "divu b=0");

        $display("[TB] start while busy is ignored");
        apply_stimulus(MD_MULT, 32'd4, 32'd5, 64'h0000_0000_0000_0014, 1'b1, 1'b0, "busy start");
        bus.start = 1'b1;
        bus.op    = MD_MTLO;
        bus.a     = 32'hBAD;
        tick();
        bus.op    = MD_MULT;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        wait_commit(3, "busy start");

        $display("[TB] flushed start");
        bus.d_md_stall = 1'b1;
        bus.start      = 1'b1;
        bus.flush      = 1'b1;
        bus.op         = MD_MULT;
        bus.a          = 32'd9;
        bus.b          = 32'd9;
        #1;
        check_output("flush stall", 64'(bus.stall), 64'd0);
        tick();
        check_output("flush busy", 64'(bus.busy), 64'd0);
        bus.op = MD_MTHI;
        bus.a  = 32'h99;
        tick();
        check_output("flush hi/lo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0014);
        bus.start      = 1'b0;
        bus.flush      = 1'b0;
        bus.d_md_stall = 1'b0;
        tick();

        $display("[TB] reset during mult");
        apply_stimulus(MD_MULT, 32'd3, 32'd3, 64'd9, 1'b0, 1'b0, "reset abort");
        tick();
        tick();
        check_output("pre-abort busy", 64'(bus.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_output("abort busy", 64'(bus.busy), 64'd0);
        check_output("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_output("post-abort busy", 64'(bus.busy), 64'd0);
        check_output("post-abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        check_output("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
